// File: rtl/sipo_pkg.sv
// ---------------------------------------------------------------------------
// sipo_pkg
// Shared types and elaboration-time helpers for the serial-to-parallel block
// loader (sipo_block_loader / sipo_shift_core).
//   state_e         : loader FSM states. FILL collects beats. HOLD presents the
//                     block in the single-buffer build. FULL means a complete
//                     block is waiting in the shift register while the output
//                     register is still occupied (double-buffer build).
//   beats_f         : number of IN_W-bit beats per DATA_W-bit block.
//   in_w_legal_f    : beat width is one of 1, 2, 4, 8, 16, 32.
//   params_legal_f  : full parameter legality check used by the top level.
// ---------------------------------------------------------------------------
package sipo_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    HOLD = 2'd1,
    FULL = 2'd2
  } state_e;

  function automatic int beats_f(input int data_w, input int in_w);
    return data_w / in_w;
  endfunction

  function automatic bit in_w_legal_f(input int in_w);
    return (in_w == 1) || (in_w == 2) || (in_w == 4) ||
           (in_w == 8) || (in_w == 16) || (in_w == 32);
  endfunction

  // A block needs at least two beats so that the beat counter has a non-zero
  // width and the shift slices stay well formed.
  function automatic bit params_legal_f(input int data_w, input int in_w);
    return in_w_legal_f(in_w) && (data_w % in_w == 0) &&
           (beats_f(data_w, in_w) >= 2);
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// ---------------------------------------------------------------------------
// sipo_shift_core
// Shift register plus beat counter for the block loader. This block has no
// handshake logic. The parent decides when a beat is accepted.
//   Build option: SIPO_DOUBLE_BUF_EN adds the shreg_nxt output. shreg_nxt
//   carries the value the shift register takes at the coming edge, so the
//   parent can capture a block in the same cycle as its last beat.
// Ports:
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   accept       : shift in_data in and advance the beat counter
//   clear        : zero the beat counter; shift register contents are kept
//   in_data      : IN_W-bit beat
//   shreg        : current shift register contents
//   shreg_nxt    : (double-buffer build only) next shift register value
//   beat_cnt     : beats accepted into the current partial block
//   last         : the counter sits at BEATS-1, so an accept completes a block
// ---------------------------------------------------------------------------
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int DATA_W    = 128,
  parameter int IN_W      = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             accept,
  input  logic                             clear,
  input  logic [IN_W-1:0]                  in_data,
  output logic [DATA_W-1:0]                shreg,
`ifdef SIPO_DOUBLE_BUF_EN
  output logic [DATA_W-1:0]                shreg_nxt,
`endif
  output logic [$clog2(DATA_W/IN_W)-1:0]   beat_cnt,
  output logic                             last
);

  localparam int BEATS = beats_f(DATA_W, IN_W);
  localparam int CNT_W = $clog2(BEATS);

  logic [DATA_W-1:0] shreg_q, shreg_d, shifted;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // LSB-first enters beats at the top, so the first beat ends up at bit 0.
  // MSB-first enters at the bottom, so the first beat ends up at the top.
  assign shifted = MSB_FIRST ? {shreg_q[DATA_W-IN_W-1:0], in_data}
                             : {in_data, shreg_q[DATA_W-1:IN_W]};

  assign last = (cnt_q == CNT_W'(BEATS - 1));

  // NOTE: every signal gets its hold value before any branch. A path that
  // leaves a signal unassigned in always_comb infers a latch.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (accept) begin
      shreg_d = shifted;
      cnt_d   = last ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // NOTE: the datapath register is reset as well as the control state. In the
  // single-buffer build out_data is this register, and out_data must read 0
  // after reset.
  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments, so every flop samples
    // pre-edge values regardless of statement order.
    if (reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign shreg    = shreg_q;
  assign beat_cnt = cnt_q;
`ifdef SIPO_DOUBLE_BUF_EN
  assign shreg_nxt = shreg_d;
`endif

endmodule

// File: rtl/sipo_block_loader.sv
// ---------------------------------------------------------------------------
// sipo_block_loader
// Serial-to-parallel block loader for the AES datapath. It collects
// DATA_W/IN_W beats of IN_W bits into one DATA_W-bit block and presents the
// block on a valid/ready interface.
//   Build option: SIPO_DOUBLE_BUF_EN adds an output register behind the shift
//   register, so a new block can fill while the previous one waits.
//   Without it, out_data is the shift register itself (FILL/HOLD machine).
// Parameters: DATA_W (block width), IN_W (beat width), MSB_FIRST (bit order).
// Ports:
//   clk, reset           : rising-edge clock, synchronous active-high reset
//   clear                : synchronous abort; drops partial and held blocks
//   in_valid/in_data     : serial beat input; in_ready is the accept signal
//   out_valid/out_data   : assembled block; out_ready takes it
//   beat_cnt             : beats accepted into the current partial block
// in_ready and out_valid come from registered state only.
// ---------------------------------------------------------------------------
module sipo_block_loader
  import sipo_pkg::*;
#(
  parameter int DATA_W    = 128,
  parameter int IN_W      = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clear,
  input  logic                             in_valid,
  input  logic [IN_W-1:0]                  in_data,
  output logic                             in_ready,
  output logic                             out_valid,
  output logic [DATA_W-1:0]                out_data,
  input  logic                             out_ready,
  output logic [$clog2(DATA_W/IN_W)-1:0]   beat_cnt
);

  if (!params_legal_f(DATA_W, IN_W)) begin : g_bad_params
    $error("sipo_block_loader: IN_W must be 1/2/4/8/16/32 and divide DATA_W into at least two beats");
  end

  state_e            state_q, state_d;
  logic              accept, deliver, last;
  logic [DATA_W-1:0] shreg;

  // clear outranks the handshake. A beat or block offered in a clear cycle is
  // not taken.
  assign accept  = in_valid  && in_ready  && !clear;
  assign deliver = out_valid && out_ready && !clear;

`ifdef SIPO_DOUBLE_BUF_EN
  logic [DATA_W-1:0] shreg_nxt;
`endif

  sipo_shift_core #(
    .DATA_W    (DATA_W),
    .IN_W      (IN_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .accept    (accept),
    .clear     (clear),
    .in_data   (in_data),
    .shreg     (shreg),
`ifdef SIPO_DOUBLE_BUF_EN
    .shreg_nxt (shreg_nxt),
`endif
    .beat_cnt  (beat_cnt),
    .last      (last)
  );

  assign in_ready = (state_q == FILL);

`ifdef SIPO_DOUBLE_BUF_EN

  logic [DATA_W-1:0] out_q, out_d;
  logic              out_valid_q, out_valid_d;

  // shreg_nxt already includes a beat accepted this cycle. Capturing it lets
  // the last beat and the transfer share one edge, so there is no bubble.
  // In FULL no beat is accepted, so shreg_nxt equals the waiting block.
  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (clear) begin
      state_d     = FILL;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (deliver) out_valid_d = 1'b0;
          if (accept && last) begin
            if (!out_valid_q || out_ready) begin
              out_d       = shreg_nxt;
              out_valid_d = 1'b1;
            end else begin
              state_d = FULL;
            end
          end
        end
        FULL: begin
          // The output register is refilled in the cycle its block leaves,
          // so out_valid stays high.
          if (deliver) begin
            out_d   = shreg_nxt;
            state_d = FILL;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_q;

`else

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = FILL;
    end else begin
      case (state_q)
        FILL:    if (accept && last) state_d = HOLD;
        HOLD:    if (deliver)        state_d = FILL;
        default:                     state_d = FILL;
      endcase
    end
  end

  assign out_valid = (state_q == HOLD);
  assign out_data  = shreg;

`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= FILL;
    else       state_q <= state_d;
  end

endmodule
